load_align_unit: RTL and testbench

- Load-side counterpart of the CPU store alignment path. Accepts one load request from the MEM stage and issues a word-aligned read on the data-memory port.
- Waits out grant and response latency, then extracts and sign/zero-extends the byte, halfword or word from the returned 32-bit word.
- Presents the result to writeback with a valid/ready handshake. Sits between the MEM stage and the DM/bus wrapper; `busy` feeds the pipeline stall logic.

---
 rtl/load_store_pkg.sv | 25 ++
 rtl/load_extract.sv | 31 +++
 rtl/load_align_unit.sv | 142 ++++++++++++++
 tb/tb_load_align_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// Shared load/store definitions: LoadCon/StoreCon encodings, load FSM state, data width.
package load_store_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        LC_LB  = 3'd0,
        LC_LH  = 3'd1,
        LC_LW  = 3'd2,
        LC_LBU = 3'd3,
        LC_LHU = 3'd4
    } load_con_e;

    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SH = 2'd1;
    localparam logic [1:0] SW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

endpackage

// File: rtl/load_extract.sv
// Lane select and sign/zero extension of a returned word for LB/LH/LW/LBU/LHU.
module load_extract
    import load_store_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      con,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        // Halfword lane follows addr[1] only, mirroring SH lane placement.
        half_sel = offset[1] ? rdata[16 +: 16] : rdata[0 +: 16];
        data     = '0;
        case (con)
            LC_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LC_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            LC_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LC_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            LC_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: one load at a time from MEM stage to the data-memory port and back to writeback.
// Optional LOAD_MISALIGN_TRAP_EN: misaligned LH/LHU/LW fault immediately without a memory access.
module load_align_unit
    import load_store_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [2:0]      ld_con,
    input  logic [RD_W-1:0] ld_rd,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_err,
    output logic            busy
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      con_q, con_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic            wb_err_q, wb_err_d;
    logic            mem_req_q, mem_req_d;
    logic            wb_valid_q, wb_valid_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] ext_data;
    logic            accept;
    logic            new_trap;

    load_extract #(.XLEN(XLEN)) u_extract (
        .rdata  (mem_rdata),
        .con    (con_q),
        .offset (addr_q[1:0]),
        .data   (ext_data)
    );

    assign ld_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && wb_ready);
    assign accept   = ld_valid && ld_ready;

`ifdef LOAD_MISALIGN_TRAP_EN
    assign new_trap = (((ld_con == LC_LH) || (ld_con == LC_LHU)) && ld_addr[0])
                   || ((ld_con == LC_LW) && (ld_addr[1:0] != 2'b00));
`else
    assign new_trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        con_d     = con_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_err_d  = wb_err_q;

        case (state_q)
            ST_REQ: begin
                if (mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = ST_DONE;
                    wb_data_d = mem_err ? '0 : ext_data;
                    wb_err_d  = mem_err;
                    wb_rd_d   = rd_q;
                end
            end
            ST_DONE: begin
                if (wb_ready) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // Acceptance in IDLE or in DONE overrides the default transition above.
        if (accept) begin
            addr_d = ld_addr;
            con_d  = ld_con;
            rd_d   = ld_rd;
            if (new_trap) begin
                state_d   = ST_DONE;
                wb_data_d = '0;
                wb_err_d  = 1'b1;
                wb_rd_d   = ld_rd;
            end else begin
                state_d = ST_REQ;
            end
        end

        mem_req_d  = (state_d == ST_REQ);
        wb_valid_d = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            con_q      <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_err_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            con_q      <= con_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_err_q   <= wb_err_d;
            mem_req_q  <= mem_req_d;
            wb_valid_q <= wb_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = {addr_q[XLEN-1:2], 2'b00};
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign wb_err   = wb_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit; expectations follow LOAD_MISALIGN_TRAP_EN when defined.
module tb_load_align_unit;

`ifdef LOAD_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_con;
    logic [4:0]  ld_rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;
    logic        busy;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_con     (ld_con),
        .ld_rd      (ld_rd),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_err     (wb_err),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  con;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_exp_q[$];
    rsp_t        rsp_q[$];
    vec_t        vecs[$];

    int  checks = 0;
    int  errors = 0;
    int  gnt_delay = 0;
    int  rv_delay = 1;
    bit  stale_window = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing/unexpected expected=protocol event", name);
    endtask

    function automatic vec_t mkv(input logic [31:0] addr, input logic [2:0] con, input logic [4:0] rd,
                                 input logic [31:0] rdata, input logic err, input logic [31:0] exp_data,
                                 input logic exp_err, input logic mis);
        vec_t v;
        v.addr = addr; v.con = con; v.rd = rd; v.rdata = rdata; v.err = err;
        v.exp_data = exp_data; v.exp_err = exp_err; v.mis = mis;
        return v;
    endfunction

    // Memory model: grant after gnt_delay cycles of mem_req, rvalid rv_delay cycles after grant.
    initial begin
        int   gcnt;
        int   rcnt;
        bit   pend;
        bit   stale_done;
        rsp_t r;
        gcnt = 0; rcnt = 0; pend = 1'b0; stale_done = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
            if (!stale_window) stale_done = 1'b0;
            if (!rst_n) begin
                gcnt = 0; pend = 1'b0;
            end else if (stale_window && !stale_done) begin
                stale_done = 1'b1;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end else if (pend) begin
                if (rcnt > 1) begin
                    rcnt--;
                end else begin
                    pend = 1'b0;
                    mem_rvalid = 1'b1;
                    if (rsp_q.size() == 0) begin
                        fail("rsp_underflow");
                    end else begin
                        r = rsp_q.pop_front();
                        mem_rdata = r.rdata;
                        mem_err   = r.err;
                    end
                end
            end else if (mem_req) begin
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1; gcnt = 0; pend = 1'b1; rcnt = rv_delay;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // Monitor: address stability, grant address, protocol, writeback scoreboard.
    initial begin
        bit          prev_req;
        bit          prev_gnt;
        logic [31:0] prev_addr;
        exp_t        e;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_req = 1'b0;
                continue;
            end
            if (mem_req && prev_req && !prev_gnt) chk("mem_addr_stable", mem_addr, prev_addr);
            if (mem_req && mem_gnt) begin
                if (addr_exp_q.size() == 0) fail("unexpected_gnt");
                else chk("mem_addr", mem_addr, addr_exp_q.pop_front());
            end
            if (mem_rvalid && !stale_window)
                chk("rvalid_only_in_wait", 32'({busy, mem_req, wb_valid}), 32'(3'b100));
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_wb_valid");
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_err", 32'(wb_err), 32'(e.err));
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
            end
            prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;
        end
    end

    task automatic issue(input vec_t v, output bit wb_at_accept);
        exp_t e;
        rsp_t r;
        bit   acc;
        bit   trap;
        acc  = 1'b0;
        trap = TRAP_EN && v.mis;
        wb_at_accept = 1'b0;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = v.addr; ld_con = v.con; ld_rd = v.rd;
        for (int i = 0; i < 200 && !acc; i++) begin
            #2;
            if (ld_ready) begin
                acc = 1'b1;
                wb_at_accept = wb_valid;
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) begin
            fail("accept_timeout");
            ld_valid = 1'b0;
            return;
        end
        e.data = trap ? 32'h0 : v.exp_data;
        e.err  = trap ? 1'b1 : v.exp_err;
        e.rd   = v.rd;
        exp_q.push_back(e);
        if (!trap) begin
            addr_exp_q.push_back({v.addr[31:2], 2'b00});
            r.rdata = v.rdata; r.err = v.err;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #2;
        chk("req_latency", 32'(mem_req), 32'(!trap));
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #2;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) fail("drain_timeout");
    endtask

    initial begin
        bit   wb_acc;
        bit   seen;
        vec_t v;

        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_con = '0; ld_rd = '0; wb_ready = 1'b1;

        vecs.push_back(mkv(32'h1003, 3'd0, 5'd1,  32'h8765_4321, 1'b0, 32'hFFFF_FF87, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1001, 3'd3, 5'd2,  32'h8765_4321, 1'b0, 32'h0000_0043, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1002, 3'd1, 5'd3,  32'h8765_4321, 1'b0, 32'hFFFF_8765, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1000, 3'd4, 5'd4,  32'h8765_4321, 1'b0, 32'h0000_4321, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1000, 3'd2, 5'd5,  32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1000, 3'd0, 5'd6,  32'h8765_4321, 1'b0, 32'h0000_0021, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1003, 3'd3, 5'd7,  32'h8765_4321, 1'b0, 32'h0000_0087, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h2002, 3'd0, 5'd8,  32'h12F4_5678, 1'b0, 32'hFFFF_FFF4, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1002, 3'd4, 5'd9,  32'h8765_4321, 1'b0, 32'h0000_8765, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1000, 3'd1, 5'd10, 32'h0000_8001, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1000, 3'd5, 5'd11, 32'h8765_4321, 1'b0, 32'h0000_0000, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1004, 3'd7, 5'd12, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0));
        vecs.push_back(mkv(32'h1008, 3'd2, 5'd13, 32'h8765_4321, 1'b1, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mkv(32'h1001, 3'd0, 5'd14, 32'h8765_4321, 1'b1, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mkv(32'h1001, 3'd1, 5'd15, 32'h8765_4321, 1'b0, 32'h0000_4321, 1'b0, 1'b1));
        vecs.push_back(mkv(32'h1001, 3'd4, 5'd16, 32'h8765_4321, 1'b0, 32'h0000_4321, 1'b0, 1'b1));
        vecs.push_back(mkv(32'h1002, 3'd2, 5'd17, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0, 1'b1));

        repeat (3) @(negedge clk);
        #2;
        chk("reset_ctrl", 32'({mem_req, wb_valid, wb_err, busy}), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_wb_rd", 32'(wb_rd), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: zero-wait grant, rvalid one cycle after grant, wb_ready high.
        foreach (vecs[k]) begin
            v = vecs[k];
            issue(v, wb_acc);
            if (!(TRAP_EN && v.mis)) begin
                @(negedge clk); #2;
                chk("wb_valid_cycle2", 32'(wb_valid), 32'd0);
                @(negedge clk); #2;
                chk("wb_valid_cycle3", 32'(wb_valid), 32'd1);
            end
            wait_idle();
        end

        // Stalled grant and response, writeback back-pressure.
        gnt_delay = 3; rv_delay = 2; wb_ready = 1'b0;
        issue(mkv(32'h2000, 3'd2, 5'd9, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0), wb_acc);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); #2;
            if (wb_valid) seen = 1'b1;
            else chk("stall_busy", 32'(busy), 32'd1);
        end
        if (!seen) fail("stall_wb_timeout");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #2;
            chk("hold_wb_valid", 32'(wb_valid), 32'd1);
            chk("hold_wb_data", wb_data, 32'hCAFE_F00D);
            chk("hold_wb_rd", 32'(wb_rd), 32'd9);
            chk("hold_wb_err", 32'(wb_err), 32'd0);
        end
        @(negedge clk);
        wb_ready = 1'b1;
        wait_idle();
        @(negedge clk); #2;
        chk("single_wb_valid", 32'(wb_valid), 32'd0);

        // Back-to-back: second request waits and is taken in DONE.
        gnt_delay = 0; rv_delay = 1;
        issue(mkv(32'h1003, 3'd0, 5'd20, 32'h8765_4321, 1'b0, 32'hFFFF_FF87, 1'b0, 1'b0), wb_acc);
        issue(mkv(32'h1002, 3'd4, 5'd21, 32'hABCD_1234, 1'b0, 32'h0000_ABCD, 1'b0, 1'b0), wb_acc);
        chk("b2b_accept_in_done", 32'(wb_acc), 32'd1);
        wait_idle();

        // Reset while waiting for the response, then a stale rvalid.
        rv_delay = 5;
        issue(mkv(32'h3000, 3'd2, 5'd22, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 1'b0), wb_acc);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midreset_ctrl", 32'({mem_req, wb_valid, wb_err, busy}), 32'd0);
        chk("midreset_wb_data", wb_data, 32'd0);
        chk("midreset_mem_addr", mem_addr, 32'd0);
        exp_q.delete(); addr_exp_q.delete(); rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale_window = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("stale_no_wb", 32'({wb_valid, busy, mem_req}), 32'd0);
            chk("stale_wb_data", wb_data, 32'd0);
        end
        stale_window = 1'b0;
        rv_delay = 1;

        chk("queues_empty", 32'(exp_q.size() + addr_exp_q.size() + rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
